// File: rtl/ram_access_ctrl_pkg.sv
// Shared types for the RAM access controller: FSM states and arbiter grant encoding.
// RAM_ACCESS_CTRL_RR_EN selects round-robin arbitration in ram_access_ctrl_arb.
package ram_access_ctrl_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_t;

endpackage

// File: rtl/ram_access_ctrl_arb.sv
// Single-grant arbiter between the write and read request channels.
// RAM_ACCESS_CTRL_RR_EN: round-robin on contention; otherwise writes always win.
module ram_access_ctrl_arb (
`ifdef RAM_ACCESS_CTRL_RR_EN
    input  logic clk,
    input  logic reset,
`endif
    input  logic enable,
    input  logic wr_valid,
    input  logic rd_valid,
    output logic wr_gnt,
    output logic rd_gnt
);
    import ram_access_ctrl_pkg::*;

    grant_t grant;

`ifdef RAM_ACCESS_CTRL_RR_EN
    // 1: read was granted at the last contended cycle, so write goes next.
    logic last_grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (enable && wr_valid && rd_valid) begin
            last_grant_q <= (grant == GNT_RD);
        end
    end
`endif

    always_comb begin
        grant = GNT_NONE;
        if (enable) begin
            if (wr_valid && rd_valid) begin
`ifdef RAM_ACCESS_CTRL_RR_EN
                grant = last_grant_q ? GNT_WR : GNT_RD;
`else
                grant = GNT_WR;
`endif
            end else if (wr_valid) begin
                grant = GNT_WR;
            end else if (rd_valid) begin
                grant = GNT_RD;
            end
        end
    end

    assign wr_gnt = (grant == GNT_WR);
    assign rd_gnt = (grant == GNT_RD);

endmodule

// File: rtl/ram_access_ctrl.sv
// Front-end for a single-port RAM: zeroes every word after reset, then arbitrates write/read
// requests onto registered RAM strobes. RAM_ACCESS_CTRL_RR_EN enables round-robin arbitration.
module ram_access_ctrl #(
    parameter int unsigned ADDRESS_MAX  = 16,
    parameter int unsigned ADDRESS_BITS = 4,
    parameter int unsigned DATA_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_req_valid,
    output logic                    wr_req_ready,
    input  logic [ADDRESS_BITS-1:0] wr_req_addr,
    input  logic [DATA_WIDTH-1:0]   wr_req_data,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ADDRESS_BITS-1:0] rd_req_addr,
    output logic                    rd_resp_valid,
    output logic [DATA_WIDTH-1:0]   rd_resp_data,
    output logic                    init_done,
    output logic                    read_memory,
    output logic                    write_memory,
    output logic [ADDRESS_BITS-1:0] address,
    output logic [DATA_WIDTH-1:0]   write_memory_data,
    input  logic [DATA_WIDTH-1:0]   read_memory_data
);
    import ram_access_ctrl_pkg::*;

    localparam logic [ADDRESS_BITS-1:0] LastAddr = ADDRESS_BITS'(ADDRESS_MAX - 1);

    state_t                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] cnt_q, cnt_d;
    logic                    read_memory_q, read_memory_d;
    logic                    write_memory_q, write_memory_d;
    logic [ADDRESS_BITS-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    init_done_q, init_done_d;
    logic                    rd_resp_valid_q;
    logic                    wr_gnt, rd_gnt;

    function automatic logic [ADDRESS_BITS-1:0] wrap_addr(input logic [ADDRESS_BITS-1:0] a);
        return ADDRESS_BITS'(32'(a) % ADDRESS_MAX);
    endfunction

    // Grants stay off until init_done so the last sweep write drains before any access.
    ram_access_ctrl_arb u_arb (
`ifdef RAM_ACCESS_CTRL_RR_EN
        .clk      (clk),
        .reset    (reset),
`endif
        .enable   (init_done_q),
        .wr_valid (wr_req_valid),
        .rd_valid (rd_req_valid),
        .wr_gnt   (wr_gnt),
        .rd_gnt   (rd_gnt)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        read_memory_d  = 1'b0;
        write_memory_d = 1'b0;
        address_d      = address_q;
        wdata_d        = wdata_q;
        init_done_d    = init_done_q | (state_q == ST_RUN);
        unique case (state_q)
            ST_INIT: begin
                write_memory_d = 1'b1;
                address_d      = cnt_q;
                wdata_d        = '0;
                cnt_d          = cnt_q + ADDRESS_BITS'(1);
                if (cnt_q == LastAddr) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (wr_gnt) begin
                    write_memory_d = 1'b1;
                    address_d      = wrap_addr(wr_req_addr);
                    wdata_d        = wr_req_data;
                end else if (rd_gnt) begin
                    read_memory_d = 1'b1;
                    address_d     = wrap_addr(rd_req_addr);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_INIT;
            cnt_q           <= '0;
            read_memory_q   <= 1'b0;
            write_memory_q  <= 1'b0;
            address_q       <= '0;
            wdata_q         <= '0;
            init_done_q     <= 1'b0;
            rd_resp_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            read_memory_q   <= read_memory_d;
            write_memory_q  <= write_memory_d;
            address_q       <= address_d;
            wdata_q         <= wdata_d;
            init_done_q     <= init_done_d;
            // RAM data appears the cycle after the read strobe.
            rd_resp_valid_q <= read_memory_q;
        end
    end

    assign wr_req_ready      = wr_gnt;
    assign rd_req_ready      = rd_gnt;
    assign rd_resp_valid     = rd_resp_valid_q;
    assign rd_resp_data      = read_memory_data;
    assign init_done         = init_done_q;
    assign read_memory       = read_memory_q;
    assign write_memory      = write_memory_q;
    assign address           = address_q;
    assign write_memory_data = wdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl with a behavioural 16x16 RAM and a read scoreboard.
// Contention expectations follow RAM_ACCESS_CTRL_RR_EN.
module tb_ram_access_ctrl;

    localparam int AMAX = 16;
    localparam int AB   = 4;
    localparam int DW   = 16;

    logic          clk;
    logic          reset;
    logic          wr_req_valid, wr_req_ready;
    logic [AB-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic          rd_req_valid, rd_req_ready;
    logic [AB-1:0] rd_req_addr;
    logic          rd_resp_valid;
    logic [DW-1:0] rd_resp_data;
    logic          init_done;
    logic          read_memory, write_memory;
    logic [AB-1:0] address;
    logic [DW-1:0] write_memory_data;
    logic [DW-1:0] read_memory_data;

    ram_access_ctrl #(
        .ADDRESS_MAX  (AMAX),
        .ADDRESS_BITS (AB),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wr_req_valid      (wr_req_valid),
        .wr_req_ready      (wr_req_ready),
        .wr_req_addr       (wr_req_addr),
        .wr_req_data       (wr_req_data),
        .rd_req_valid      (rd_req_valid),
        .rd_req_ready      (rd_req_ready),
        .rd_req_addr       (rd_req_addr),
        .rd_resp_valid     (rd_resp_valid),
        .rd_resp_data      (rd_resp_data),
        .init_done         (init_done),
        .read_memory       (read_memory),
        .write_memory      (write_memory),
        .address           (address),
        .write_memory_data (write_memory_data),
        .read_memory_data  (read_memory_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read on posedge, write on negedge.
    logic [DW-1:0] ram [AMAX];
    always @(posedge clk) if (read_memory) read_memory_data <= ram[address];
    always @(negedge clk) if (write_memory) ram[address] <= write_memory_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } resp_t;
    resp_t sb[$];

    // Reference state: memory contents in grant order and the expected RAM-side registers.
    logic [DW-1:0] mdl [AMAX];
    logic          exp_wm, exp_rm;
    logic [AB-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                check("resp_valid", 32'(rd_resp_valid), 32'(1));
                check("resp_data", 32'(rd_resp_data), 32'(sb[0].data));
                void'(sb.pop_front());
            end else begin
                check("resp_idle", 32'(rd_resp_valid), 32'(0));
            end
        end
    end

    task automatic check_bus();
        check("bus_wm", 32'(write_memory), 32'(exp_wm));
        check("bus_rm", 32'(read_memory), 32'(exp_rm));
        check("bus_addr", 32'(address), 32'(exp_addr));
        if (exp_wm) check("bus_data", 32'(write_memory_data), 32'(exp_data));
    endtask

    // One request cycle: check previous cycle's RAM outputs, drive, check readies, record grant.
    task automatic step(input logic wv, input logic [AB-1:0] wa, input logic [DW-1:0] wd,
                        input logic rv, input logic [AB-1:0] ra, input logic ewr, input logic erd);
        resp_t r;
        @(negedge clk);
        check_bus();
        wr_req_valid = wv;
        wr_req_addr  = wa;
        wr_req_data  = wd;
        rd_req_valid = rv;
        rd_req_addr  = ra;
        #1;
        check("wr_ready", 32'(wr_req_ready), 32'(ewr));
        check("rd_ready", 32'(rd_req_ready), 32'(erd));
        exp_wm = 1'b0;
        exp_rm = 1'b0;
        if (wv && wr_req_ready) begin
            mdl[wa]  = wd;
            exp_wm   = 1'b1;
            exp_addr = wa;
            exp_data = wd;
        end else if (rv && rd_req_ready) begin
            r.data   = mdl[ra];
            r.cyc    = cyc + 2;
            sb.push_back(r);
            exp_rm   = 1'b1;
            exp_addr = ra;
        end
    endtask

    task automatic check_init();
        for (int i = 0; i < AMAX; i++) begin
            @(negedge clk);
            check("init_wm", 32'(write_memory), 32'(1));
            check("init_rm", 32'(read_memory), 32'(0));
            check("init_addr", 32'(address), 32'(i));
            check("init_data", 32'(write_memory_data), 32'(0));
            check("init_done_low", 32'(init_done), 32'(0));
            check("init_wr_ready", 32'(wr_req_ready), 32'(0));
            check("init_rd_ready", 32'(rd_req_ready), 32'(0));
        end
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        @(negedge clk);
        check("init_done_high", 32'(init_done), 32'(1));
        check("post_init_wm", 32'(write_memory), 32'(0));
        check("post_init_rm", 32'(read_memory), 32'(0));
        for (int i = 0; i < AMAX; i++) mdl[i] = '0;
        exp_wm   = 1'b0;
        exp_rm   = 1'b0;
        exp_addr = AB'(AMAX - 1);
        exp_data = '0;
    endtask

    // Called at a negedge; requests are held high to show readies stay low.
    task automatic do_reset();
        reset        = 1'b1;
        wr_req_valid = 1'b1;
        rd_req_valid = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        check("rst_wm", 32'(write_memory), 32'(0));
        check("rst_rm", 32'(read_memory), 32'(0));
        check("rst_addr", 32'(address), 32'(0));
        check("rst_data", 32'(write_memory_data), 32'(0));
        check("rst_resp_valid", 32'(rd_resp_valid), 32'(0));
        check("rst_init_done", 32'(init_done), 32'(0));
        check("rst_wr_ready", 32'(wr_req_ready), 32'(0));
        check("rst_rd_ready", 32'(rd_req_ready), 32'(0));
        reset = 1'b0;
        check_init();
    endtask

    typedef struct {
        logic          wv;
        logic [AB-1:0] wa;
        logic [DW-1:0] wd;
        logic          rv;
        logic [AB-1:0] ra;
        logic          ewr;
        logic          erd;
    } vec_t;

    function automatic vec_t mk(input logic wv, input int wa, input int wd,
                                input logic rv, input int ra);
        vec_t v;
        v.wv  = wv;
        v.wa  = AB'(wa);
        v.wd  = DW'(wd);
        v.rv  = rv;
        v.ra  = AB'(ra);
        v.ewr = wv;
        v.erd = rv & ~wv;
        return v;
    endfunction

    vec_t tbl[16];
    logic ew;

    initial begin
        tbl[0]  = mk(1, 3, 'hBEEF, 0, 0);  // write then read same address: new data
        tbl[1]  = mk(0, 0, 0, 1, 3);
        tbl[2]  = mk(0, 0, 0, 1, 7);       // untouched word reads back zero
        tbl[3]  = mk(0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 5, 'h1111, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 1, 5);       // read then write same address: old data
        tbl[7]  = mk(1, 5, 'h2222, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 5);
        tbl[10] = mk(1, 15, 'hA5A5, 0, 0);
        tbl[11] = mk(0, 0, 0, 1, 15);
        tbl[12] = mk(1, 0, 'h1234, 0, 0);
        tbl[13] = mk(0, 0, 0, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0);

        wr_req_addr = '0;
        wr_req_data = '0;
        rd_req_addr = '0;
        do_reset();

        foreach (tbl[i])
            step(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, tbl[i].ewr, tbl[i].erd);

        // Contention for four cycles.
        for (int i = 0; i < 4; i++) begin
`ifdef RAM_ACCESS_CTRL_RR_EN
            ew = (i % 2 == 0);
`else
            ew = 1'b1;
`endif
            step(1'b1, AB'(10), DW'(16'h0A00 + i), 1'b1, AB'(11), ew, ~ew);
        end
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, AB'(10), 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, AB'(11), 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);

        // Reset the cycle after a read is accepted: response dropped, sweep restarts.
        step(1'b0, '0, '0, 1'b1, AB'(3), 1'b0, 1'b1);
        @(negedge clk);
        do_reset();
        step(1'b0, '0, '0, 1'b1, AB'(3), 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'(0));
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
